// File: rtl/mig_line_xfer_pkg.sv
// Shared MIG command codes and FSM state encoding for the cache-line <-> MIG transfer block.
package mig_line_xfer_pkg;

   localparam logic [2:0] MigCmdWr = 3'b000;
   localparam logic [2:0] MigCmdRd = 3'b001;

   typedef enum logic [2:0] {
      StIdle,
      StWrData,
      StWrCmd,
      StRdCmd,
      StRdWait,
      StRsp
   } state_e;

endpackage

// File: rtl/mig_line_xfer_if.sv
// MIG DDR2 user-interface bundle: address FIFO, write-data FIFO and read-data return.
interface mig_line_xfer_if #(
   parameter int unsigned APPDATA_WIDTH = 128,
   parameter int unsigned ADDR_WIDTH    = 31
);

   logic                         app_af_afull;
   logic                         app_wdf_afull;
   logic                         app_af_wren;
   logic [2:0]                   app_af_cmd;
   logic [ADDR_WIDTH-1:0]        app_af_addr;
   logic                         app_wdf_wren;
   logic [APPDATA_WIDTH-1:0]     app_wdf_data;
   logic [APPDATA_WIDTH/8-1:0]   app_wdf_mask_data;
   logic                         rd_data_valid;
   logic [APPDATA_WIDTH-1:0]     rd_data_fifo_out;

   modport master (
      input  app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
      output app_af_wren, app_af_cmd, app_af_addr, app_wdf_wren, app_wdf_data, app_wdf_mask_data
   );

   modport slave (
      output app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
      input  app_af_wren, app_af_cmd, app_af_addr, app_wdf_wren, app_wdf_data, app_wdf_mask_data
   );

endinterface

// File: rtl/mig_line_xfer_beat_gather.sv
// Read-line assembly: stores BEATS MIG beats in arrival order and flags the final beat.
module mig_line_xfer_beat_gather #(
   parameter int unsigned APPDATA_WIDTH = 128,
   parameter int unsigned BEATS         = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clr_i,
   input  logic                             en_i,
   input  logic                             beat_valid_i,
   input  logic [APPDATA_WIDTH-1:0]         beat_data_i,
   output logic [BEATS*APPDATA_WIDTH-1:0]   line_o,
   output logic                             done_o
);

   localparam int unsigned CntW = $clog2(BEATS) + 1;
   localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

   logic [BEATS*APPDATA_WIDTH-1:0] slots_q, slots_d;
   logic [CntW-1:0]                cnt_q, cnt_d;

   always_comb begin
      slots_d = slots_q;
      cnt_d   = cnt_q;
      done_o  = 1'b0;
      if (clr_i) begin
         slots_d = '0;
         cnt_d   = '0;
      end else if (en_i && beat_valid_i) begin
         slots_d[cnt_q*APPDATA_WIDTH +: APPDATA_WIDTH] = beat_data_i;
         cnt_d  = cnt_q + 1'b1;
         done_o = (cnt_q == LastBeat);
      end
   end

   // Expose the next-state view so the final beat is part of the line on the done cycle.
   assign line_o = slots_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         slots_q <= '0;
         cnt_q   <= '0;
      end else begin
         slots_q <= slots_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/mig_line_xfer.sv
// One-line-per-request transfer between the cache controller and the MIG app_* port.
// Optional read watchdog enabled by defining MIG_LINE_XFER_READ_TIMEOUT_EN.
module mig_line_xfer
   import mig_line_xfer_pkg::*;
#(
   parameter int unsigned APPDATA_WIDTH  = 128,
   parameter int unsigned BEATS          = 2,
   parameter int unsigned ADDR_WIDTH     = 31,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic                               req_we,
   input  logic [ADDR_WIDTH-1:0]              req_addr,
   input  logic [BEATS*APPDATA_WIDTH-1:0]     req_wdata,
   input  logic [BEATS*APPDATA_WIDTH/8-1:0]   req_wmask,
   output logic                               rsp_valid,
   input  logic                               rsp_ready,
   output logic                               rsp_we,
   output logic [BEATS*APPDATA_WIDTH-1:0]     rsp_rdata,
   output logic                               rsp_err,
   mig_line_xfer_if.master                    mig
);

   localparam int unsigned LineW = BEATS * APPDATA_WIDTH;
   localparam int unsigned MaskW = APPDATA_WIDTH / 8;
   localparam int unsigned CntW  = $clog2(BEATS) + 1;
   localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

   state_e                    state_q, state_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [LineW-1:0]          wdata_q, wdata_d;
   logic [LineW/8-1:0]        wmask_q, wmask_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic                      rsp_we_q, rsp_we_d;
   logic                      rsp_err_q, rsp_err_d;
   logic [LineW-1:0]          rsp_rdata_q, rsp_rdata_d;
   logic                      af_wren_q, af_wren_d;
   logic [2:0]                af_cmd_q, af_cmd_d;
   logic [ADDR_WIDTH-1:0]     af_addr_q, af_addr_d;
   logic                      wdf_wren_q, wdf_wren_d;
   logic [APPDATA_WIDTH-1:0]  wdf_data_q, wdf_data_d;
   logic [MaskW-1:0]          wdf_mask_q, wdf_mask_d;

   logic                      gather_clr;
   logic                      gather_done;
   logic [LineW-1:0]          gather_line;

`ifdef MIG_LINE_XFER_READ_TIMEOUT_EN
   localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TimerW-1:0]         timer_q, timer_d;
`else
   logic                      unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   mig_line_xfer_beat_gather #(
      .APPDATA_WIDTH (APPDATA_WIDTH),
      .BEATS         (BEATS)
   ) u_gather (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (gather_clr),
      .en_i         (state_q == StRdWait),
      .beat_valid_i (mig.rd_data_valid),
      .beat_data_i  (mig.rd_data_fifo_out),
      .line_o       (gather_line),
      .done_o       (gather_done)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_we_d    = rsp_we_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      af_wren_d   = 1'b0;
      af_cmd_d    = af_cmd_q;
      af_addr_d   = af_addr_q;
      wdf_wren_d  = 1'b0;
      wdf_data_d  = wdf_data_q;
      wdf_mask_d  = wdf_mask_q;
      gather_clr  = 1'b0;
`ifdef MIG_LINE_XFER_READ_TIMEOUT_EN
      timer_d     = timer_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wmask_d = req_wmask;
               cnt_d   = '0;
               state_d = req_we ? StWrData : StRdCmd;
            end
         end
         StWrData: begin
            // Data beats go out ahead of the address so MIG never sees a command without data.
            if (!mig.app_wdf_afull) begin
               wdf_wren_d = 1'b1;
               wdf_data_d = wdata_q[cnt_q*APPDATA_WIDTH +: APPDATA_WIDTH];
               wdf_mask_d = wmask_q[cnt_q*MaskW +: MaskW];
               cnt_d      = cnt_q + 1'b1;
               if (cnt_q == LastBeat) state_d = StWrCmd;
            end
         end
         StWrCmd: begin
            if (!mig.app_af_afull) begin
               af_wren_d   = 1'b1;
               af_cmd_d    = MigCmdWr;
               af_addr_d   = addr_q;
               rsp_valid_d = 1'b1;
               rsp_we_d    = 1'b1;
               rsp_err_d   = 1'b0;
               state_d     = StRsp;
            end
         end
         StRdCmd: begin
            if (!mig.app_af_afull) begin
               af_wren_d  = 1'b1;
               af_cmd_d   = MigCmdRd;
               af_addr_d  = addr_q;
               cnt_d      = '0;
               gather_clr = 1'b1;
`ifdef MIG_LINE_XFER_READ_TIMEOUT_EN
               timer_d    = '0;
`endif
               state_d    = StRdWait;
            end
         end
         StRdWait: begin
            if (gather_done) begin
               rsp_valid_d = 1'b1;
               rsp_we_d    = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = gather_line;
               state_d     = StRsp;
            end
`ifdef MIG_LINE_XFER_READ_TIMEOUT_EN
            else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
               rsp_valid_d = 1'b1;
               rsp_we_d    = 1'b0;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = gather_line;
               state_d     = StRsp;
            end else begin
               timer_d = timer_q + 1'b1;
            end
`endif
         end
         StRsp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         af_wren_q   <= 1'b0;
         af_cmd_q    <= MigCmdWr;
         af_addr_q   <= '0;
         wdf_wren_q  <= 1'b0;
         wdf_data_q  <= '0;
         wdf_mask_q  <= '0;
`ifdef MIG_LINE_XFER_READ_TIMEOUT_EN
         timer_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         af_wren_q   <= af_wren_d;
         af_cmd_q    <= af_cmd_d;
         af_addr_q   <= af_addr_d;
         wdf_wren_q  <= wdf_wren_d;
         wdf_data_q  <= wdf_data_d;
         wdf_mask_q  <= wdf_mask_d;
`ifdef MIG_LINE_XFER_READ_TIMEOUT_EN
         timer_q     <= timer_d;
`endif
      end
   end

   assign req_ready             = (state_q == StIdle);
   assign rsp_valid             = rsp_valid_q;
   assign rsp_we                = rsp_we_q;
   assign rsp_err               = rsp_err_q;
   assign rsp_rdata             = rsp_rdata_q;
   assign mig.app_af_wren       = af_wren_q;
   assign mig.app_af_cmd        = af_cmd_q;
   assign mig.app_af_addr       = af_addr_q;
   assign mig.app_wdf_wren      = wdf_wren_q;
   assign mig.app_wdf_data      = wdf_data_q;
   assign mig.app_wdf_mask_data = wdf_mask_q;

endmodule
